temp_bcd_converter: RTL and testbench
=====================================

Name: temp_bcd_converter

Overview:
- Converts a binary temperature reading into four BCD digits for the four-digit seven-segment display stage.
- Sits directly upstream of the display driver. Its four digit outputs drive that stage's temp1..temp4 inputs (thousands..units), zero-extended to 32 bits.
- Uses an iterative double-dabble (shift-add-3) datapath with a start/busy/done handshake.
- Digit outputs change only at conversion completion, so the display never shows a half-converted value.

Parameters:
- DATA_W, 14, width of temp_in. Legal range 14..20. Must be at least 14 so that 9999 is representable.
- MAX_VAL, 9999, saturation ceiling applied to the input before conversion.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk, 0 = reset
- start  input  1  conversion request; sampled only in IDLE
- temp_in  input  DATA_W  binary temperature, unsigned (see Optional Feature)
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the digit outputs update
- ovf  output  1  high if the last converted input was clamped to MAX_VAL; updates with the digits
- digit3  output  4  thousands BCD digit; drives display temp1
- digit2  output  4  hundreds BCD digit; drives display temp2
- digit1  output  4  tens BCD digit; drives display temp3
- digit0  output  4  units BCD digit; drives display temp4

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, busy=0, done=0, ovf=0, digit3..digit0=0.
  - Shift register, scratch BCD and bit counter cleared.
  - Reset overrides everything, including mid-conversion. The partial result is discarded and the outputs return to 0.
- States: IDLE, SHIFT, PUBLISH.
- IDLE:
  - done=0 except for the single cycle that follows PUBLISH.
  - On an edge with start=1:
    - Capture sat = min(temp_in, MAX_VAL) into the shift register.
    - Set the internal ovf_pend flag to (temp_in > MAX_VAL).
    - Clear the 16-bit scratch BCD.
    - Set bit counter = DATA_W, set busy=1, go to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT (one edge per input bit, DATA_W edges total):
  - First, every scratch nibble >= 5 gets +3 (4-bit add, no carry between nibbles).
  - Then {scratch, shiftreg} shifts left by 1.
  - Counter decrements. When the counter goes 1 -> 0, go to PUBLISH.
- PUBLISH (one edge):
  - digit3..digit0 <= scratch[15:0], ovf <= ovf_pend.
  - done=1 and busy=0 for the following cycle; return to IDLE.
- Latency:
  - start is sampled at edge E; digits and done are valid after edge E+DATA_W+1.
  - done lasts exactly one cycle.
- Back-to-back operation:
  - start=1 during the done cycle is accepted, since the block is already in IDLE.
  - Throughput is one conversion per DATA_W+2 cycles.
- start while busy is ignored and not queued.
- temp_in is sampled only at the accept edge. Later changes do not affect the conversion in flight.
- Digit values are always 0..9. Outputs hold their last value indefinitely between conversions.
- Simultaneous reset=0 and start=1: reset wins and the start is dropped.

Optional Feature:
- Macro: NEG_TEMP_EN.
- Defined:
  - temp_in is two's complement.
  - Negative input: the magnitude is converted and the saturation ceiling becomes 999.
  - At PUBLISH, digit3 is forced to 4'hA (minus-sign code).
  - The most-negative input converts as magnitude 2^(DATA_W-1), then clamps to 999 with ovf=1.
  - Positive inputs behave as in the undefined case.
- Undefined: temp_in is unsigned and digit3 is never above 9.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> digits 0,0,0,0, busy=0, done=0, ovf=0.
- Basic conversion: temp_in=1234 with a start pulse -> busy for DATA_W+1 cycles; then done pulse one cycle; digits 1,2,3,4; ovf=0.
- Saturation: temp_in=16383 (DATA_W=14) -> digits 9,9,9,9, ovf=1. Next conversion of 25 -> digits 0,0,2,5, ovf=0.
- Ignored/back-to-back start:
  - Start 456, re-pulse start with temp_in=789 mid-conversion -> 0,4,5,6.
  - Start during the done cycle -> accepted; 0,7,8,9 after DATA_W+2 cycles.
- Reset mid-conversion: start 5678, assert reset at shift 5 -> outputs 0, busy=0, no done pulse. Next conversion of 42 -> 0,0,4,2.
- NEG_TEMP_EN: temp_in=-37 -> digits A,0,3,7, ovf=0. temp_in=-1500 -> A,9,9,9, ovf=1.

Source files
------------

// File: rtl/temp_bcd_converter.sv
// temp_bcd_converter: iterative double-dabble binary-to-4-digit-BCD converter with start/busy/done handshake
// Ports: clk, reset (sync, active-low), start, temp_in[DATA_W] in; busy, done (1-cycle), ovf, digit3..digit0 (thousands..units) out
// Optional: NEG_TEMP_EN treats temp_in as two's complement, shows 4'hA in digit3 for negatives, clamps magnitude to 999
module temp_bcd_converter #(
  parameter int DATA_W  = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] temp_in,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [3:0]        digit3,
  output logic [3:0]        digit2,
  output logic [3:0]        digit1,
  output logic [3:0]        digit0
);
  typedef enum logic [1:0] {IDLE, SHIFT, PUBLISH} state_t;
  localparam int CW = $clog2(DATA_W + 1);
  state_t state, state_nxt;
  logic [DATA_W-1:0] sr, mag, limit, sat;
  logic [15:0] bcd, bcd_adj;
  logic [CW-1:0] cnt;
  logic ovf_pend, neg_pend, neg;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
                state == SHIFT ? (cnt == CW'(1) ? PUBLISH : SHIFT) : IDLE;
  always_comb
    busy = state != IDLE;
  always_comb begin
`ifdef NEG_TEMP_EN
    neg = temp_in[DATA_W-1];
`else
    neg = 1'b0;
`endif
    mag   = neg ? -temp_in : temp_in;
    limit = neg ? DATA_W'(999) : DATA_W'(MAX_VAL);
    sat   = mag > limit ? limit : mag;
  end
  // add-3 correction per nibble before each shift keeps every nibble a valid BCD digit
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk)
    if (!reset) begin
      sr       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      neg_pend <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      {digit3, digit2, digit1, digit0} <= '0;
    end else begin
      done <= state == PUBLISH;
      if (state == IDLE && start) begin
        sr       <= sat;
        ovf_pend <= mag > limit;
        neg_pend <= neg;
        bcd      <= '0;
        cnt      <= CW'(DATA_W);
      end
      if (state == SHIFT) begin
        {bcd, sr} <= {bcd_adj, sr} << 1;
        cnt       <= cnt - CW'(1);
      end
      if (state == PUBLISH) begin
        {digit3, digit2, digit1, digit0} <= {neg_pend ? 4'hA : bcd[15:12], bcd[11:0]};
        ovf <= ovf_pend;
      end
    end
endmodule

// File: tb/tb_temp_bcd_converter.sv
// tb_temp_bcd_converter: randomized and directed checks of temp_bcd_converter against an arithmetic reference model
module tb_temp_bcd_converter;
  localparam int DW = 14;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [DW-1:0] temp_in = '0;
  logic busy, done, ovf;
  logic [3:0] digit3, digit2, digit1, digit0;
  int total = 0, fails = 0;
  always #5 clk = ~clk;
  temp_bcd_converter #(.DATA_W(DW), .MAX_VAL(9999)) dut (
    .clk(clk), .reset(reset), .start(start), .temp_in(temp_in),
    .busy(busy), .done(done), .ovf(ovf),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [16:0] model(input logic [DW-1:0] v);
    int m, lim;
    logic neg;
    logic [16:0] r;
    m = int'(v);
    lim = 9999;
    neg = 1'b0;
`ifdef NEG_TEMP_EN
    if (v[DW-1]) begin
      neg = 1'b1;
      m = (1 << DW) - m;
      lim = 999;
    end
`endif
    r[16] = m > lim;
    if (m > lim) m = lim;
    r[15:0] = {neg ? 4'hA : 4'(m / 1000), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
    return r;
  endfunction
  task automatic wait_done(input int n0, output int n, output int nb);
    n = n0;
    nb = 0;
    while (done !== 1'b1 && n < 60) begin
      nb += int'(busy);
      @(negedge clk);
      n++;
    end
  endtask
  task automatic check_out(input logic [16:0] e);
    chk("digits", 32'({digit3, digit2, digit1, digit0}), 32'(e[15:0]));
    chk("ovf", 32'(ovf), 32'(e[16]));
    chk("busy_at_done", 32'(busy), 0);
  endtask
  task automatic convert(input logic [DW-1:0] v);
    int n, nb;
    @(negedge clk);
    temp_in = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    temp_in = DW'($urandom);
    wait_done(0, n, nb);
    chk("latency", n, DW + 1);
    chk("busy_cycles", nb, DW + 1);
    check_out(model(v));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
  endtask
  initial begin
    int n, nb, nd;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_digits", 32'({digit3, digit2, digit1, digit0}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    convert(DW'(1234));
    convert(DW'(16383));
    convert(DW'(25));
    convert(DW'(9999));
    convert(DW'(10000));
    convert(DW'(0));
    for (int i = 0; i < 8; i++) convert(DW'($urandom_range(0, (1 << DW) - 1)));
    @(negedge clk);
    temp_in = DW'(456);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    temp_in = DW'(789);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, n, nb);
    chk("ignored_start_latency", n, DW + 1);
    check_out(model(DW'(456)));
    temp_in = DW'(789);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, nb);
    chk("back_to_back_latency", n, DW + 2);
    check_out(model(DW'(789)));
    @(negedge clk);
    temp_in = DW'(5678);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    chk("midrst_digits", 32'({digit3, digit2, digit1, digit0}), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    nd = 0;
    repeat (DW + 4) begin
      nd += int'(done) + int'(busy);
      @(negedge clk);
    end
    chk("midrst_no_activity", nd, 0);
    convert(DW'(42));
`ifdef NEG_TEMP_EN
    convert(DW'(-37));
    convert(DW'(-1500));
    convert(DW'(-8192));
    convert(DW'(-999));
    for (int i = 0; i < 4; i++) convert(DW'($urandom_range(0, (1 << DW) - 1)));
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
